// File: rtl/led_key_ctrl.sv
// led_key_ctrl: debounces two active-low push-buttons and turns accepted presses into
// chaser commands (step rate, direction, run/stop) plus a 1-cycle step-enable tick.
// Build macro LONG_PRESS_EN: a long hold of key1 toggles run/stop, and the key1
// direction toggle moves to the end of the release debounce (short presses only).
module led_key_ctrl #(
  parameter int unsigned DEB_CYC   = 1_000_000,
  parameter int unsigned LONG_CYC  = 50_000_000,
  parameter int unsigned TICK_BASE = 50_000_000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [1:0] key,
  output logic       tick,
  output logic       dir,
  output logic [1:0] speed,
  output logic       run,
  output logic [1:0] press
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned TW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DB_PRESS = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] DB_REL   = 2'd3;

  logic [1:0]    sync1, sync2;
  logic [1:0]    st_q  [2];
  logic [1:0]    st_d  [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    acc;
  logic          dir_d;
  logic          run_d;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tlast;

  // Two-stage synchroniser for the asynchronous, bouncing keys
  always_ff @(posedge clk) begin
    if (!rs) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Per-key debounce FSM next state; acc flags the cycle a press is accepted
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    acc   = 2'b00;
    for (int k = 0; k < 2; k++) begin
      case (st_q[k])
        IDLE: begin
          if (!sync2[k]) begin
            st_d[k]  = DB_PRESS;
            cnt_d[k] = '0;
          end
        end
        DB_PRESS: begin
          if (sync2[k]) begin
            st_d[k] = IDLE;
          end else if (cnt_q[k] == DEB_LAST) begin
            st_d[k] = HELD;
            acc[k]  = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        HELD: begin
          if (sync2[k]) begin
            st_d[k]  = DB_REL;
            cnt_d[k] = '0;
          end
        end
        DB_REL: begin
          if (!sync2[k]) begin
            st_d[k] = HELD;
          end else if (cnt_q[k] == DEB_LAST) begin
            st_d[k] = IDLE;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        default: st_d[k] = IDLE;
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_CYC + 1);
  localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_CYC);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);

  logic [HW-1:0] hcnt;
  logic          long_hit;
  logic          run_q;
  logic          held_now;
  logic          long_fire;
  logic          rel_done1;

  assign held_now  = (st_q[1] == HELD) && !sync2[1];
  // Hold counter saturates at LONG_CYC, so the toggle fires only once per hold
  assign long_fire = held_now && (hcnt == LONG_LAST);
  assign rel_done1 = (st_q[1] == DB_REL) && sync2[1] && (cnt_q[1] == DEB_LAST);
  assign run_d     = long_fire ? ~run_q : run_q;
  assign run       = run_q;

  // Key1 hold timer, long-press flag and run/stop state
  always_ff @(posedge clk) begin
    if (!rs) begin
      hcnt     <= '0;
      long_hit <= 1'b0;
      run_q    <= 1'b1;
    end else begin
      if (acc[1]) begin
        hcnt     <= '0;
        long_hit <= 1'b0;
      end else if (held_now && (hcnt != LONG_SAT)) begin
        hcnt <= hcnt + 1'b1;
      end
      if (long_fire) begin
        long_hit <= 1'b1;
        run_q    <= ~run_q;
      end
    end
  end

  // Direction flips once the release is confirmed, unless this hold was a long press
  always_comb begin
    dir_d = dir;
    if (rel_done1 && !long_hit) dir_d = ~dir;
  end
`else
  assign run_d = 1'b1;
  assign run   = 1'b1;

  // Direction flips on every accepted key1 press
  always_comb begin
    dir_d = dir;
    if (acc[1]) dir_d = ~dir;
  end
`endif

  // FSM state, press pulses and command registers
  always_ff @(posedge clk) begin
    if (!rs) begin
      for (int k = 0; k < 2; k++) begin
        st_q[k]  <= IDLE;
        cnt_q[k] <= '0;
      end
      press <= 2'b00;
      dir   <= 1'b0;
      speed <= 2'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      press <= acc;
      dir   <= dir_d;
      if (acc[0]) speed <= speed + 2'd1;
    end
  end

  // Terminal count of the current tick period
  always_comb begin
    tlast = TW'((TICK_BASE >> speed) - 1);
  end

  // Tick generator: any speed change or run edge restarts a full period
  always_ff @(posedge clk) begin
    if (!rs) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else if (!run || !run_d || acc[0]) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else if (tcnt == tlast) begin
      tcnt <= '0;
      tick <= 1'b1;
    end else begin
      tcnt <= tcnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_key_ctrl.sv
// Bench for led_key_ctrl: directed scenarios plus randomized key traffic checked against
// a run-length based behavioural model. Define LONG_PRESS_EN to also cover long presses.
module tb_led_key_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;
  localparam int unsigned TB  = 16;

  logic       clk = 1'b0;
  logic       rs  = 1'b0;
  logic [1:0] key = 2'b11;
  logic       tick, dir, run;
  logic [1:0] speed, press;

  int errors = 0;
  int checks = 0;

  // Model state: key samples delayed by the synchroniser, debounced level per key,
  // length of the current run of samples disagreeing with that level, and commands.
  logic [1:0] m_hist0, m_hist1;
  logic [1:0] m_pressed;
  int         m_run_len [2];
  int         m_held;
  logic       m_long;
  logic [1:0] m_speed;
  logic       m_dir, m_run, m_tick;
  logic [1:0] m_press;
  int         m_since;

  always #5 clk = ~clk;

  led_key_ctrl #(
    .DEB_CYC  (DEB),
    .LONG_CYC (LNG),
    .TICK_BASE(TB)
  ) dut (
    .clk  (clk),
    .rs   (rs),
    .key  (key),
    .tick (tick),
    .dir  (dir),
    .speed(speed),
    .run  (run),
    .press(press)
  );

  task automatic model_update(input logic r, input logic [1:0] k);
    logic [1:0] syn;
    logic [1:0] np;
    logic       rd1;
    logic       run_old;
    int         per;
    if (!r) begin
      m_hist0 = 2'b11; m_hist1 = 2'b11; m_pressed = 2'b00;
      m_run_len[0] = 0; m_run_len[1] = 0; m_held = 0; m_long = 1'b0;
      m_speed = 2'd0; m_dir = 1'b0; m_run = 1'b1; m_tick = 1'b0;
      m_press = 2'b00; m_since = 0;
      return;
    end
    syn = m_hist1;
    np = 2'b00;
    rd1 = 1'b0;
    run_old = m_run;
    per = TB >> m_speed;
    for (int i = 0; i < 2; i++) begin
      logic dis;
      dis = m_pressed[i] ? syn[i] : !syn[i];
      if (dis) begin
        m_run_len[i]++;
        // A level change is accepted after DEB+1 consecutive opposite samples
        if (m_run_len[i] == DEB + 1) begin
          m_pressed[i] = !m_pressed[i];
          m_run_len[i] = 0;
          if (m_pressed[i]) np[i] = 1'b1;
          else if (i == 1) rd1 = 1'b1;
        end
      end else begin
        if (i == 1 && m_pressed[1] && m_run_len[1] == 0 && m_held < LNG) begin
          m_held++;
`ifdef LONG_PRESS_EN
          if (m_held == LNG) begin
            m_run  = !m_run;
            m_long = 1'b1;
          end
`endif
        end
        m_run_len[i] = 0;
      end
    end
`ifdef LONG_PRESS_EN
    if (rd1 && !m_long) m_dir = !m_dir;
`else
    if (np[1]) m_dir = !m_dir;
`endif
    if (np[1]) begin
      m_held = 0;
      m_long = 1'b0;
    end
    if (!run_old || !m_run || np[0]) begin
      m_since = 0;
      m_tick  = 1'b0;
    end else if (m_since + 1 == per) begin
      m_since = 0;
      m_tick  = 1'b1;
    end else begin
      m_since++;
      m_tick = 1'b0;
    end
    if (np[0]) m_speed = m_speed + 2'd1;
    m_press = np;
    m_hist1 = m_hist0;
    m_hist0 = k;
  endtask

  // One clock: inputs seen at the edge feed the model, outputs settle by the falling edge
  task automatic step();
    logic [1:0] k_s;
    logic       r_s;
    k_s = key;
    r_s = rs;
    @(posedge clk);
    model_update(r_s, k_s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int t1, t2;
    rs = 1'b0;
    key = 2'b11;
    repeat (3) step();
    checks++; if (press !== 2'b00) begin errors++;
      $display("FAIL reset_press: got %b expected 00", press); end
    checks++; if (dir !== 1'b0) begin errors++;
      $display("FAIL reset_dir: got %b expected 0", dir); end
    checks++; if (speed !== 2'd0) begin errors++;
      $display("FAIL reset_speed: got %0d expected 0", speed); end
    checks++; if (run !== 1'b1) begin errors++;
      $display("FAIL reset_run: got %b expected 1", run); end
    checks++; if (tick !== 1'b0) begin errors++;
      $display("FAIL reset_tick: got %b expected 0", tick); end
    rs = 1'b1;
    t1 = -1;
    t2 = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (tick === 1'b1) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
    end
    checks++; if (t1 !== 16) begin errors++;
      $display("FAIL reset_first_tick: got cycle %0d expected 16", t1); end
    checks++; if (t2 - t1 !== 16) begin errors++;
      $display("FAIL reset_tick_period: got %0d expected 16", t2 - t1); end
  endtask

  task automatic test_glitch_and_press();
    int seen, lat, t1, t2;
    key[0] = 1'b0;
    seen = 0;
    repeat (3) begin step(); if (press[0] === 1'b1) seen++; end
    key[0] = 1'b1;
    repeat (10) begin step(); if (press[0] === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++;
      $display("FAIL glitch_press: got %0d pulses expected 0", seen); end
    checks++; if (speed !== 2'd0) begin errors++;
      $display("FAIL glitch_speed: got %0d expected 0", speed); end
    key[0] = 1'b0;
    lat = -1;
    seen = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (press[0] === 1'b1) begin seen++; if (lat < 0) lat = n; end
    end
    key[0] = 1'b1;
    repeat (10) begin step(); if (press[0] === 1'b1) seen++; end
    checks++; if (lat !== DEB + 3) begin errors++;
      $display("FAIL press_latency: got %0d expected %0d", lat, DEB + 3); end
    checks++; if (seen !== 1) begin errors++;
      $display("FAIL press_count: got %0d expected 1", seen); end
    checks++; if (speed !== 2'd1) begin errors++;
      $display("FAIL press_speed: got %0d expected 1", speed); end
    t1 = -1;
    t2 = -1;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (tick === 1'b1) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
    end
    checks++; if (t2 - t1 !== 8) begin errors++;
      $display("FAIL speed1_period: got %0d expected 8", t2 - t1); end
  endtask

  task automatic test_speed_cycle();
    int pe, g1, g2, per;
    logic [1:0] es;
    rs = 1'b0;
    step();
    rs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      es = 2'(i + 1);
      per = TB >> es;
      key[0] = 1'b0;
      pe = -1;
      for (int n = 1; n <= 20 && pe < 0; n++) begin
        step();
        if (press[0] === 1'b1) pe = n;
      end
      checks++; if (pe !== DEB + 3) begin errors++;
        $display("FAIL cycle%0d_latency: got %0d expected %0d", i, pe, DEB + 3); end
      checks++; if (speed !== es) begin errors++;
        $display("FAIL cycle%0d_speed: got %0d expected %0d", i, speed, es); end
      g1 = -1;
      g2 = -1;
      for (int n = 1; n <= 40; n++) begin
        if (n == 2) key[0] = 1'b1;
        step();
        if (tick === 1'b1) begin
          if (g1 < 0) g1 = n;
          else if (g2 < 0) g2 = n;
        end
      end
      checks++; if (g1 !== per) begin errors++;
        $display("FAIL cycle%0d_first_tick: got %0d expected %0d", i, g1, per); end
      checks++; if (g2 - g1 !== per) begin errors++;
        $display("FAIL cycle%0d_period: got %0d expected %0d", i, g2 - g1, per); end
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [1:0] pv;
    rs = 1'b0;
    step();
    rs = 1'b1;
    key = 2'b00;
    lat = -1;
    pv = 2'b00;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      step();
      if (press !== 2'b00) begin pv = press; lat = n; end
    end
    step();
    key = 2'b11;
    repeat (12) step();
    checks++; if (pv !== 2'b11) begin errors++;
      $display("FAIL simul_press: got %b expected 11", pv); end
    checks++; if (lat !== DEB + 3) begin errors++;
      $display("FAIL simul_latency: got %0d expected %0d", lat, DEB + 3); end
    checks++; if (dir !== 1'b1) begin errors++;
      $display("FAIL simul_dir: got %b expected 1", dir); end
    checks++; if (speed !== 2'd1) begin errors++;
      $display("FAIL simul_speed: got %0d expected 1", speed); end
  endtask

  task automatic test_reset_mid_press();
    int lat, cnt;
    key = 2'b10;
    repeat (10) step();
    rs = 1'b0;
    step();
    checks++; if (speed !== 2'd0) begin errors++;
      $display("FAIL midrst_speed: got %0d expected 0", speed); end
    checks++; if (dir !== 1'b0) begin errors++;
      $display("FAIL midrst_dir: got %b expected 0", dir); end
    checks++; if (press !== 2'b00) begin errors++;
      $display("FAIL midrst_press: got %b expected 00", press); end
    rs = 1'b1;
    lat = -1;
    cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (press[0] === 1'b1) begin cnt++; if (lat < 0) lat = n; end
    end
    key = 2'b11;
    repeat (10) begin step(); if (press[0] === 1'b1) cnt++; end
    checks++; if (lat !== DEB + 3) begin errors++;
      $display("FAIL midrst_latency: got %0d expected %0d", lat, DEB + 3); end
    checks++; if (cnt !== 1) begin errors++;
      $display("FAIL midrst_count: got %0d expected 1", cnt); end
    checks++; if (speed !== 2'd1) begin errors++;
      $display("FAIL midrst_speed_after: got %0d expected 1", speed); end
  endtask

`ifdef LONG_PRESS_EN
  task automatic test_long_press();
    int nt;
    rs = 1'b0;
    step();
    rs = 1'b1;
    key = 2'b01;
    nt = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n >= 28 && tick === 1'b1) nt++;
    end
    key = 2'b11;
    repeat (15) begin step(); if (tick === 1'b1) nt++; end
    checks++; if (run !== 1'b0) begin errors++;
      $display("FAIL long_run: got %b expected 0", run); end
    checks++; if (dir !== 1'b0) begin errors++;
      $display("FAIL long_dir: got %b expected 0", dir); end
    key = 2'b01;
    repeat (8) begin step(); if (tick === 1'b1) nt++; end
    key = 2'b11;
    repeat (12) begin step(); if (tick === 1'b1) nt++; end
    checks++; if (dir !== 1'b1) begin errors++;
      $display("FAIL short_dir: got %b expected 1", dir); end
    checks++; if (run !== 1'b0) begin errors++;
      $display("FAIL short_run: got %b expected 0", run); end
    checks++; if (nt !== 0) begin errors++;
      $display("FAIL stopped_ticks: got %0d expected 0", nt); end
  endtask
`endif

  task automatic test_random();
    int len;
    rs = 1'b0;
    step();
    rs = 1'b1;
    for (int seg = 0; seg < 160; seg++) begin
      if ($urandom_range(0, 1) == 0) key[0] = ~key[0];
      if ($urandom_range(0, 1) == 0) key[1] = ~key[1];
      if ($urandom_range(0, 29) == 0) rs = 1'b0;
      len = $urandom_range(1, 14);
      for (int n = 0; n < len; n++) begin
        step();
        rs = 1'b1;
        checks++; if (press !== m_press) begin errors++;
          $display("FAIL rnd_press: got %b expected %b at %0t", press, m_press, $time); end
        checks++; if (speed !== m_speed) begin errors++;
          $display("FAIL rnd_speed: got %0d expected %0d at %0t", speed, m_speed, $time); end
        checks++; if (dir !== m_dir) begin errors++;
          $display("FAIL rnd_dir: got %b expected %b at %0t", dir, m_dir, $time); end
        checks++; if (run !== m_run) begin errors++;
          $display("FAIL rnd_run: got %b expected %b at %0t", run, m_run, $time); end
        checks++; if (tick !== m_tick) begin errors++;
          $display("FAIL rnd_tick: got %b expected %b at %0t", tick, m_tick, $time); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch_and_press();
    test_speed_cycle();
    test_simultaneous();
    test_reset_mid_press();
`ifdef LONG_PRESS_EN
    test_long_press();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
